udp_port_switch_rr: RTL and testbench
=====================================

// Module: udp_port_switch_rr
// PURPOSE
// - N-channel UDP port switch between the UDP stack's single header/payload pair and N user channels.
// - TX: fair round-robin arbitration; the packet lock is held from header through payload tlast.
// - RX: demux by destination port against a runtime-writable port table; unmatched packets are drained.
// - Drop-in successor to the fixed-port switch in the ethernet top level.
// PARAMETERS
// - PORT_COUNT     4                    number of user channels, 1..16
// - DATA_WIDTH     8                    payload tdata width
// - DEFAULT_PORTS  {1234,1235,1236,1237}  per-channel reset port number; entries are enabled at reset
// PORTS
// - clk              in   1            clock
// - reset            in   1            async, active-high
// - s_tx_hdr_*       in   N x (valid,80b data) / out ready   user TX hdr {dst_ip32,src_port16,dst_port16,len16}
// - s_tx_t*          in   N x (data,valid,last,user) / out N ready   user TX payload
// - m_tx_hdr_*       out  valid, 80b data / in ready   to UDP stack
// - m_tx_t*          out  data, valid, last, user / in ready
// - s_rx_hdr_*       in   valid, 80b data / out ready   from UDP stack (same header layout)
// - s_rx_t*          in   data, valid, last, user / out ready
// - m_rx_hdr_*       out  N x (valid,80b data) / in N ready   to user channels
// - m_rx_t*          out  N x (data,valid,last,user) / in N ready
// - cfg_we           in   1            port-table write strobe
// - cfg_idx          in   $clog2(N)    table entry to write
// - cfg_port         in   16           port value
// - cfg_en           in   1            entry enable
// - drop_count       out  32           dropped RX packets (UDP_PORT_SWITCH_STATS_EN only)
// BEHAVIOUR
// - Reset values:
//   - all valid/ready outputs 0; RR pointer 0.
//   - Table = DEFAULT_PORTS, all entries enabled; drop_count 0.
//   - Both FSMs in IDLE.
// - Mid-packet reset: both FSMs abort to IDLE immediately. No trailing beats are emitted.
// - TX FSM IDLE->HDR->PAY->IDLE:
//   - IDLE: grant the first channel with hdr_valid, scanning from ptr, ptr+1, ... mod N. Grant is registered: 1 cycle.
//   - HDR: m_tx_hdr mirrors the granted channel combinationally. Handshake -> PAY.
//   - PAY: payload passes through combinationally. Non-granted channels see tready=0.
//   - tlast handshake -> IDLE and ptr = grant+1 mod N.
//   - Back-to-back packets cost 1 idle cycle each.
// - RX FSM IDLE->LOOKUP->HDR->PAY|DROP->IDLE:
//   - IDLE: s_rx_hdr_ready=1 for one beat; latch the header.
//   - LOOKUP (1 cycle): compare dst_port against enabled entries. Lowest matching index wins.
//     No match -> DROP with drop_count+1, saturating at 2^32-1.
//   - HDR: assert m_rx_hdr_valid[sel] only. Handshake -> PAY.
//   - PAY: pass the payload to sel with backpressure honoured. tlast handshake -> IDLE.
//   - DROP: s_rx_tready=1 until the tlast beat; no output activity.
// - Config:
//   - A write takes effect the next cycle.
//   - The routing of an in-flight RX packet is latched and unaffected.
//   - cfg_we with cfg_idx>=N is ignored.
// - Duplicate ports are legal; the lowest index wins. A disabled entry never matches.
// - tuser passes through unchanged. Headers are not modified.
// CONFIGURATION
// - UDP_PORT_SWITCH_STATS_EN defined: drop_count is a 32-bit saturating counter.
// - UDP_PORT_SWITCH_STATS_EN undefined: drop_count is tied to 0 and the counter is absent.
//   Drop behaviour is otherwise identical.
// TESTING
// - RR fairness: N=4, ch0-3 each queue 3 pkts (2 beats) -> grant order 0,1,2,3,0,1,2,3,...
//   Each packet's payload stays contiguous.
// - Lock: ch0 pkt with m_tx_tready toggling 50%, ch1 hdr_valid asserted mid-payload
//   -> ch1 is not granted until ch0's tlast handshake.
// - RX route: hdr dst_port=1236 -> only m_rx_hdr_valid[2] asserts; 5 payload beats arrive on ch2 intact.
// - Drop: dst_port=9999 with 7 beats -> all beats consumed, no m_rx valid asserted, drop_count=1 (STATS_EN).
// - Reconfig: write idx1=5000 during a ch1 RX packet -> current packet completes on ch1.
//   A later packet to 5000 goes to ch1; a later packet to 1235 is dropped.
// - Reset mid-PAY on both paths -> all valids 0 next cycle; the next packet routes correctly from IDLE.

Source files
------------

// File: rtl/udp_port_switch_rr.sv
// udp_port_switch_rr: N-channel UDP header/payload switch with a round-robin TX mux and a port-table RX demux.
// Define UDP_PORT_SWITCH_STATS_EN to build the saturating drop_count statistics counter.
module udp_port_switch_rr #(
    parameter int PORT_COUNT = 4,
    parameter int DATA_WIDTH = 8,
    parameter logic [16*PORT_COUNT-1:0] DEFAULT_PORTS = {16'd1237, 16'd1236, 16'd1235, 16'd1234},
    localparam int IDXW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [PORT_COUNT-1:0]            s_tx_hdr_valid,
    input  logic [PORT_COUNT*80-1:0]         s_tx_hdr_data,
    output logic [PORT_COUNT-1:0]            s_tx_hdr_ready,
    input  logic [PORT_COUNT*DATA_WIDTH-1:0] s_tx_tdata,
    input  logic [PORT_COUNT-1:0]            s_tx_tvalid,
    input  logic [PORT_COUNT-1:0]            s_tx_tlast,
    input  logic [PORT_COUNT-1:0]            s_tx_tuser,
    output logic [PORT_COUNT-1:0]            s_tx_tready,
    output logic                             m_tx_hdr_valid,
    output logic [79:0]                      m_tx_hdr_data,
    input  logic                             m_tx_hdr_ready,
    output logic [DATA_WIDTH-1:0]            m_tx_tdata,
    output logic                             m_tx_tvalid,
    output logic                             m_tx_tlast,
    output logic                             m_tx_tuser,
    input  logic                             m_tx_tready,
    input  logic                             s_rx_hdr_valid,
    input  logic [79:0]                      s_rx_hdr_data,
    output logic                             s_rx_hdr_ready,
    input  logic [DATA_WIDTH-1:0]            s_rx_tdata,
    input  logic                             s_rx_tvalid,
    input  logic                             s_rx_tlast,
    input  logic                             s_rx_tuser,
    output logic                             s_rx_tready,
    output logic [PORT_COUNT-1:0]            m_rx_hdr_valid,
    output logic [PORT_COUNT*80-1:0]         m_rx_hdr_data,
    input  logic [PORT_COUNT-1:0]            m_rx_hdr_ready,
    output logic [PORT_COUNT*DATA_WIDTH-1:0] m_rx_tdata,
    output logic [PORT_COUNT-1:0]            m_rx_tvalid,
    output logic [PORT_COUNT-1:0]            m_rx_tlast,
    output logic [PORT_COUNT-1:0]            m_rx_tuser,
    input  logic [PORT_COUNT-1:0]            m_rx_tready,
    input  logic                             cfg_we,
    input  logic [IDXW-1:0]                  cfg_idx,
    input  logic [15:0]                      cfg_port,
    input  logic                             cfg_en,
    output logic [31:0]                      drop_count
);

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_HDR = 2'd1, TX_PAY = 2'd2} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE = 3'd0, RX_LOOKUP = 3'd1, RX_HDR = 3'd2,
                              RX_PAY = 3'd3, RX_DROP = 3'd4} rx_state_t;

    tx_state_t             tx_state_q, tx_state_d;
    logic [IDXW-1:0]       grant_q, grant_d, ptr_q, ptr_d, tx_pick_s, tx_cand_s;
    logic                  tx_found_s;
    rx_state_t             rx_state_q, rx_state_d;
    logic [IDXW-1:0]       sel_q, sel_d, rx_match_s;
    logic                  rx_hit_s, rx_armed_q;
    logic [79:0]           rx_hdr_q, rx_hdr_d;
    logic [15:0]           port_q [PORT_COUNT];
    logic [15:0]           port_d [PORT_COUNT];
    logic [PORT_COUNT-1:0] en_q, en_d;

    // Round-robin scan: first requesting channel at ptr, ptr+1, ... wrapping at PORT_COUNT
    always_comb begin
        tx_found_s = 1'b0;
        tx_pick_s  = ptr_q;
        tx_cand_s  = ptr_q;
        for (int i = 0; i < PORT_COUNT; i++) begin
            tx_cand_s  = IDXW'((int'(ptr_q) + i) % PORT_COUNT);
            tx_pick_s  = (!tx_found_s && s_tx_hdr_valid[tx_cand_s]) ? tx_cand_s : tx_pick_s;
            tx_found_s = tx_found_s | s_tx_hdr_valid[tx_cand_s];
        end
    end

    // TX FSM: the grant is held from header through the payload tlast handshake
    always_comb begin
        tx_state_d     = tx_state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        s_tx_hdr_ready = {PORT_COUNT{1'b0}};
        s_tx_tready    = {PORT_COUNT{1'b0}};
        m_tx_hdr_valid = 1'b0;
        m_tx_hdr_data  = 80'd0;
        m_tx_tdata     = {DATA_WIDTH{1'b0}};
        m_tx_tvalid    = 1'b0;
        m_tx_tlast     = 1'b0;
        m_tx_tuser     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_found_s) begin
                    grant_d    = tx_pick_s;
                    tx_state_d = TX_HDR;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_HDR: begin
                m_tx_hdr_valid          = s_tx_hdr_valid[grant_q];
                m_tx_hdr_data           = s_tx_hdr_data[int'(grant_q)*80 +: 80];
                s_tx_hdr_ready[grant_q] = m_tx_hdr_ready;
                if (m_tx_hdr_valid && m_tx_hdr_ready) begin
                    tx_state_d = TX_PAY;
                end else begin
                    tx_state_d = TX_HDR;
                end
            end
            TX_PAY: begin
                m_tx_tdata           = s_tx_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                m_tx_tvalid          = s_tx_tvalid[grant_q];
                m_tx_tlast           = s_tx_tlast[grant_q];
                m_tx_tuser           = s_tx_tuser[grant_q];
                s_tx_tready[grant_q] = m_tx_tready;
                if (m_tx_tvalid && m_tx_tready && m_tx_tlast) begin
                    tx_state_d = TX_IDLE;
                    ptr_d      = (int'(grant_q) == PORT_COUNT - 1) ? {IDXW{1'b0}} : grant_q + 1'b1;
                end else begin
                    tx_state_d = TX_PAY;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Port-table match on the latched header; scanning downward lets the lowest index win
    always_comb begin
        rx_hit_s   = 1'b0;
        rx_match_s = {IDXW{1'b0}};
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            rx_match_s = (en_q[i] && (port_q[i] == rx_hdr_q[31:16])) ? IDXW'(i) : rx_match_s;
            rx_hit_s   = rx_hit_s | (en_q[i] && (port_q[i] == rx_hdr_q[31:16]));
        end
    end

    // RX FSM: route is latched in sel_q so table writes never disturb an in-flight packet
    always_comb begin
        rx_state_d     = rx_state_q;
        sel_d          = sel_q;
        rx_hdr_d       = rx_hdr_q;
        s_rx_hdr_ready = 1'b0;
        s_rx_tready    = 1'b0;
        m_rx_hdr_valid = {PORT_COUNT{1'b0}};
        m_rx_tvalid    = {PORT_COUNT{1'b0}};
        case (rx_state_q)
            RX_IDLE: begin
                s_rx_hdr_ready = rx_armed_q;
                if (rx_armed_q && s_rx_hdr_valid) begin
                    rx_hdr_d   = s_rx_hdr_data;
                    rx_state_d = RX_LOOKUP;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_LOOKUP: begin
                if (rx_hit_s) begin
                    sel_d      = rx_match_s;
                    rx_state_d = RX_HDR;
                end else begin
                    rx_state_d = RX_DROP;
                end
            end
            RX_HDR: begin
                m_rx_hdr_valid[sel_q] = 1'b1;
                if (m_rx_hdr_ready[sel_q]) begin
                    rx_state_d = RX_PAY;
                end else begin
                    rx_state_d = RX_HDR;
                end
            end
            RX_PAY: begin
                m_rx_tvalid[sel_q] = s_rx_tvalid;
                s_rx_tready        = m_rx_tready[sel_q];
                if (s_rx_tvalid && m_rx_tready[sel_q] && s_rx_tlast) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_PAY;
                end
            end
            RX_DROP: begin
                s_rx_tready = 1'b1;
                if (s_rx_tvalid && s_rx_tlast) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DROP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign m_rx_hdr_data = {PORT_COUNT{rx_hdr_q}};
    assign m_rx_tdata    = {PORT_COUNT{s_rx_tdata}};
    assign m_rx_tlast    = {PORT_COUNT{s_rx_tlast}};
    assign m_rx_tuser    = {PORT_COUNT{s_rx_tuser}};

    // Port-table write port; out-of-range indices are discarded
    always_comb begin
        port_d = port_q;
        en_d   = en_q;
        if (cfg_we && (int'(cfg_idx) < PORT_COUNT)) begin
            port_d[cfg_idx] = cfg_port;
            en_d[cfg_idx]   = cfg_en;
        end else begin
            en_d = en_q;
        end
    end

    // State registers; rx_armed_q keeps s_rx_hdr_ready low while reset is asserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            grant_q    <= {IDXW{1'b0}};
            ptr_q      <= {IDXW{1'b0}};
            rx_state_q <= RX_IDLE;
            sel_q      <= {IDXW{1'b0}};
            rx_hdr_q   <= 80'd0;
            rx_armed_q <= 1'b0;
            en_q       <= {PORT_COUNT{1'b1}};
            for (int i = 0; i < PORT_COUNT; i++) begin
                port_q[i] <= DEFAULT_PORTS[16*i +: 16];
            end
        end else begin
            tx_state_q <= tx_state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            rx_state_q <= rx_state_d;
            sel_q      <= sel_d;
            rx_hdr_q   <= rx_hdr_d;
            rx_armed_q <= 1'b1;
            en_q       <= en_d;
            port_q     <= port_d;
        end
    end

`ifdef UDP_PORT_SWITCH_STATS_EN
    logic [31:0] drop_q, drop_d;

    // Saturating count of packets that matched no enabled entry
    always_comb begin
        if ((rx_state_q == RX_LOOKUP) && !rx_hit_s && (drop_q != 32'hFFFF_FFFF)) begin
            drop_d = drop_q + 32'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Drop counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 32'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 32'd0;
`endif

endmodule

// File: tb/tb_udp_port_switch_rr.sv
// Directed self-checking bench for udp_port_switch_rr (PORT_COUNT=4, DATA_WIDTH=8).
module tb_udp_port_switch_rr;
    localparam int N  = 4;
    localparam int DW = 8;
`ifdef UDP_PORT_SWITCH_STATS_EN
    localparam logic [31:0] EXP_DROP1 = 32'd1;
    localparam logic [31:0] EXP_DROP2 = 32'd2;
`else
    localparam logic [31:0] EXP_DROP1 = 32'd0;
    localparam logic [31:0] EXP_DROP2 = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] s_tx_hdr_valid, s_tx_hdr_ready, s_tx_tvalid, s_tx_tlast, s_tx_tuser, s_tx_tready;
    logic [N*80-1:0] s_tx_hdr_data;
    logic [N*DW-1:0] s_tx_tdata;
    logic m_tx_hdr_valid, m_tx_hdr_ready, m_tx_tvalid, m_tx_tlast, m_tx_tuser, m_tx_tready;
    logic [79:0] m_tx_hdr_data;
    logic [DW-1:0] m_tx_tdata;
    logic s_rx_hdr_valid, s_rx_hdr_ready, s_rx_tvalid, s_rx_tlast, s_rx_tuser, s_rx_tready;
    logic [79:0] s_rx_hdr_data;
    logic [DW-1:0] s_rx_tdata;
    logic [N-1:0] m_rx_hdr_valid, m_rx_hdr_ready, m_rx_tvalid, m_rx_tlast, m_rx_tuser, m_rx_tready;
    logic [N*80-1:0] m_rx_hdr_data;
    logic [N*DW-1:0] m_rx_tdata;
    logic cfg_we, cfg_en;
    logic [1:0] cfg_idx;
    logic [15:0] cfg_port;
    logic [31:0] drop_count;

    int checks = 0;
    int errors = 0;

    udp_port_switch_rr #(.PORT_COUNT(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .s_tx_hdr_valid(s_tx_hdr_valid), .s_tx_hdr_data(s_tx_hdr_data), .s_tx_hdr_ready(s_tx_hdr_ready),
        .s_tx_tdata(s_tx_tdata), .s_tx_tvalid(s_tx_tvalid), .s_tx_tlast(s_tx_tlast),
        .s_tx_tuser(s_tx_tuser), .s_tx_tready(s_tx_tready),
        .m_tx_hdr_valid(m_tx_hdr_valid), .m_tx_hdr_data(m_tx_hdr_data), .m_tx_hdr_ready(m_tx_hdr_ready),
        .m_tx_tdata(m_tx_tdata), .m_tx_tvalid(m_tx_tvalid), .m_tx_tlast(m_tx_tlast),
        .m_tx_tuser(m_tx_tuser), .m_tx_tready(m_tx_tready),
        .s_rx_hdr_valid(s_rx_hdr_valid), .s_rx_hdr_data(s_rx_hdr_data), .s_rx_hdr_ready(s_rx_hdr_ready),
        .s_rx_tdata(s_rx_tdata), .s_rx_tvalid(s_rx_tvalid), .s_rx_tlast(s_rx_tlast),
        .s_rx_tuser(s_rx_tuser), .s_rx_tready(s_rx_tready),
        .m_rx_hdr_valid(m_rx_hdr_valid), .m_rx_hdr_data(m_rx_hdr_data), .m_rx_hdr_ready(m_rx_hdr_ready),
        .m_rx_tdata(m_rx_tdata), .m_rx_tvalid(m_rx_tvalid), .m_rx_tlast(m_rx_tlast),
        .m_rx_tuser(m_rx_tuser), .m_rx_tready(m_rx_tready),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_port(cfg_port), .cfg_en(cfg_en),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        s_tx_hdr_valid = '0; s_tx_hdr_data = '0; s_tx_tdata = '0;
        s_tx_tvalid = '0; s_tx_tlast = '0; s_tx_tuser = '0;
        m_tx_hdr_ready = 1'b0; m_tx_tready = 1'b0;
        s_rx_hdr_valid = 1'b0; s_rx_hdr_data = '0; s_rx_tdata = '0;
        s_rx_tvalid = 1'b0; s_rx_tlast = 1'b0; s_rx_tuser = 1'b0;
        m_rx_hdr_ready = '0; m_rx_tready = '0;
        cfg_we = 1'b0; cfg_idx = 2'd0; cfg_port = 16'd0; cfg_en = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        s_tx_hdr_valid = 4'hF;
        s_rx_hdr_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({s_tx_hdr_ready, s_tx_tready, m_tx_hdr_valid, m_tx_tvalid, s_rx_hdr_ready, s_rx_tready,
             m_rx_hdr_valid, m_rx_tvalid} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {s_tx_hdr_ready, s_tx_tready, m_tx_hdr_valid,
                     m_tx_tvalid, s_rx_hdr_ready, s_rx_tready, m_rx_hdr_valid, m_rx_tvalid});
        end
        checks++;
        if (drop_count !== 32'd0) begin
            errors++; $display("FAIL reset_drop_count: got %0d required 0", drop_count);
        end
        idle_inputs();
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (s_rx_hdr_ready !== 1'b1) begin
            errors++; $display("FAIL idle_rx_hdr_ready: got %b required 1", s_rx_hdr_ready);
        end
    endtask

    task automatic test_rr_fairness();
        int left[N], phase[N], beat[N], pktno[N];
        int k, exp_ch, rbeat, done;
        logic [79:0] exp_hdr;
        logic [DW+1:0] exp_pay;
        k = 0; exp_ch = 0; rbeat = 0; done = 0;
        for (int c = 0; c < N; c++) begin
            left[c] = 3; phase[c] = 0; beat[c] = 0; pktno[c] = 0;
        end
        for (int cyc = 0; cyc < 300 && done < 12; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                s_tx_hdr_valid[c] = (phase[c] == 0) && (left[c] > 0);
                s_tx_hdr_data[c*80 +: 80] = {32'(c), 16'(pktno[c]), 16'd4000, 16'd2};
                s_tx_tvalid[c] = (phase[c] == 1);
                s_tx_tdata[c*DW +: DW] = 8'(c*16 + pktno[c]*2 + beat[c]);
                s_tx_tlast[c] = (beat[c] == 1);
                s_tx_tuser[c] = beat[c][0];
            end
            m_tx_hdr_ready = 1'b1;
            m_tx_tready = 1'b1;
            #1;
            if (m_tx_hdr_valid && m_tx_hdr_ready) begin
                exp_ch = k % N;
                exp_hdr = {32'(exp_ch), 16'(k / N), 16'd4000, 16'd2};
                checks++;
                if (m_tx_hdr_data !== exp_hdr) begin
                    errors++; $display("FAIL rr_grant_%0d: got %h required %h", k, m_tx_hdr_data, exp_hdr);
                end
                k++;
                rbeat = 0;
            end
            if (m_tx_tvalid && m_tx_tready) begin
                exp_pay = {8'(exp_ch*16 + ((k-1) / N)*2 + rbeat), rbeat == 1, rbeat[0]};
                checks++;
                if ({m_tx_tdata, m_tx_tlast, m_tx_tuser} !== exp_pay) begin
                    errors++; $display("FAIL rr_payload_%0d: got %h required %h", k-1,
                                       {m_tx_tdata, m_tx_tlast, m_tx_tuser}, exp_pay);
                end
                rbeat++;
                if (rbeat == 2) done++;
            end
            for (int c = 0; c < N; c++) begin
                if (s_tx_hdr_valid[c] && s_tx_hdr_ready[c]) phase[c] = 1;
                if (s_tx_tvalid[c] && s_tx_tready[c]) begin
                    if (beat[c] == 1) begin
                        beat[c] = 0; phase[c] = 0; left[c]--; pktno[c]++;
                    end else begin
                        beat[c]++;
                    end
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (done !== 12) begin
            errors++; $display("FAIL rr_packets_done: got %0d required 12", done);
        end
    endtask

    task automatic test_lock();
        int ph0, b0, ph1, granted1;
        bit req1;
        ph0 = 0; b0 = 0; ph1 = 0; granted1 = 0; req1 = 1'b0;
        for (int cyc = 0; cyc < 200 && ph1 != 2; cyc++) begin
            @(negedge clk);
            s_tx_hdr_valid = {2'b00, req1 && (ph1 == 0), ph0 == 0};
            s_tx_hdr_data[0 +: 80]  = {32'd0, 16'd7, 16'd4001, 16'd4};
            s_tx_hdr_data[80 +: 80] = {32'd1, 16'd8, 16'd4001, 16'd1};
            s_tx_tvalid = {2'b00, ph1 == 1, ph0 == 1};
            s_tx_tdata[0 +: 8] = 8'hA0 + 8'(b0);
            s_tx_tdata[8 +: 8] = 8'hB0;
            s_tx_tlast = {2'b00, 1'b1, b0 == 3};
            s_tx_tuser = 4'b0000;
            m_tx_hdr_ready = 1'b1;
            m_tx_tready = (cyc % 2 == 1);
            #1;
            if (req1 && ph0 != 2) begin
                checks++;
                if ({s_tx_hdr_ready[1], m_tx_hdr_valid} !== 2'b00) begin
                    errors++; $display("FAIL lock_hold: got %b required 00", {s_tx_hdr_ready[1], m_tx_hdr_valid});
                end
            end
            if (m_tx_tvalid && m_tx_tready && ph0 == 1) begin
                checks++;
                if ({m_tx_tdata, m_tx_tlast} !== {8'hA0 + 8'(b0), b0 == 3}) begin
                    errors++; $display("FAIL lock_payload_%0d: got %h required %h", b0,
                                       {m_tx_tdata, m_tx_tlast}, {8'hA0 + 8'(b0), b0 == 3});
                end
            end
            if (m_tx_hdr_valid && m_tx_hdr_ready && req1) begin
                checks++;
                if (m_tx_hdr_data !== {32'd1, 16'd8, 16'd4001, 16'd1}) begin
                    errors++; $display("FAIL lock_ch1_hdr: got %h required ch1 header", m_tx_hdr_data);
                end
                granted1 = 1;
            end
            if (s_tx_hdr_valid[0] && s_tx_hdr_ready[0]) ph0 = 1;
            if (s_tx_tvalid[0] && s_tx_tready[0]) begin
                if (b0 == 3) ph0 = 2; else b0++;
            end
            if (s_tx_hdr_valid[1] && s_tx_hdr_ready[1]) ph1 = 1;
            if (s_tx_tvalid[1] && s_tx_tready[1]) ph1 = 2;
            if (ph0 == 1 && b0 >= 1) req1 = 1'b1;
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({granted1 == 1, ph1 == 2} !== 2'b11) begin
            errors++; $display("FAIL lock_ch1_complete: got granted=%0d phase=%0d required 1 2", granted1, ph1);
        end
    endtask

    task automatic rx_packet(input logic [15:0] dport, input int nbeats, input int exp_ch,
                             input logic [7:0] seed, input bit cfg_mid);
        int sent, recv;
        bit hdr_sent, hdr_seen, done;
        logic [N-1:0] oh;
        logic [79:0] hdr;
        hdr = {32'hC0A8_0001, 16'd555, dport, 16'(nbeats)};
        oh = (exp_ch >= 0) ? 4'(1 << exp_ch) : 4'd0;
        sent = 0; recv = 0; hdr_sent = 1'b0; hdr_seen = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            s_rx_hdr_valid = !hdr_sent;
            s_rx_hdr_data = hdr;
            s_rx_tvalid = hdr_sent && (sent < nbeats);
            s_rx_tdata = seed + 8'(sent);
            s_rx_tlast = (sent == nbeats - 1);
            s_rx_tuser = sent[0];
            m_rx_hdr_ready = 4'hF;
            m_rx_tready = (cyc % 2 == 0) ? 4'hF : 4'h0;
            cfg_we = cfg_mid && (sent == 2);
            cfg_idx = 2'd1; cfg_port = 16'd5000; cfg_en = 1'b1;
            #1;
            checks++;
            if (((m_rx_hdr_valid | m_rx_tvalid) & ~oh) !== 4'd0) begin
                errors++; $display("FAIL rx_stray_valid port %0d: got hdr=%b data=%b allowed %b",
                                   dport, m_rx_hdr_valid, m_rx_tvalid, oh);
            end
            if (exp_ch >= 0 && m_rx_hdr_valid[exp_ch]) begin
                checks++;
                if (m_rx_hdr_data[exp_ch*80 +: 80] !== hdr) begin
                    errors++; $display("FAIL rx_hdr port %0d: got %h required %h", dport,
                                       m_rx_hdr_data[exp_ch*80 +: 80], hdr);
                end
                hdr_seen = 1'b1;
            end
            if (exp_ch >= 0 && m_rx_tvalid[exp_ch] && m_rx_tready[exp_ch]) begin
                checks++;
                if ({m_rx_tdata[exp_ch*8 +: 8], m_rx_tlast[exp_ch], m_rx_tuser[exp_ch]} !==
                    {seed + 8'(recv), recv == nbeats - 1, recv[0]}) begin
                    errors++; $display("FAIL rx_beat_%0d port %0d: got %h required %h", recv, dport,
                                       {m_rx_tdata[exp_ch*8 +: 8], m_rx_tlast[exp_ch], m_rx_tuser[exp_ch]},
                                       {seed + 8'(recv), recv == nbeats - 1, recv[0]});
                end
                recv++;
            end
            if (s_rx_hdr_valid && s_rx_hdr_ready) hdr_sent = 1'b1;
            if (s_rx_tvalid && s_rx_tready) sent++;
            done = (sent == nbeats) && (exp_ch < 0 || recv == nbeats);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (!(sent == nbeats && (exp_ch < 0 || (recv == nbeats && hdr_seen)))) begin
            errors++; $display("FAIL rx_complete port %0d: got sent=%0d recv=%0d hdr=%b required %0d beats",
                               dport, sent, recv, hdr_seen, nbeats);
        end
    endtask

    task automatic test_rx_route();
        rx_packet(16'd1236, 5, 2, 8'h30, 1'b0);
    endtask

    task automatic test_drop();
        rx_packet(16'd9999, 7, -1, 8'h50, 1'b0);
        checks++;
        if (drop_count !== EXP_DROP1) begin
            errors++; $display("FAIL drop_count_1: got %0d required %0d", drop_count, EXP_DROP1);
        end
    endtask

    task automatic test_reconfig();
        rx_packet(16'd1235, 4, 1, 8'h70, 1'b1);
        rx_packet(16'd5000, 2, 1, 8'h80, 1'b0);
        rx_packet(16'd1235, 2, -1, 8'h90, 1'b0);
        checks++;
        if (drop_count !== EXP_DROP2) begin
            errors++; $display("FAIL drop_count_2: got %0d required %0d", drop_count, EXP_DROP2);
        end
    endtask

    task automatic test_mid_reset();
        bit got;
        @(negedge clk);
        s_tx_hdr_valid = 4'b0100;
        s_tx_hdr_data[160 +: 80] = {32'd2, 16'd9, 16'd4002, 16'd8};
        s_tx_tvalid = 4'b0100; s_tx_tdata[16 +: 8] = 8'hC1;
        m_tx_hdr_ready = 1'b1; m_tx_tready = 1'b1;
        s_rx_hdr_valid = 1'b1; s_rx_hdr_data = {32'hC0A8_0002, 16'd556, 16'd1234, 16'd8};
        s_rx_tvalid = 1'b1; s_rx_tdata = 8'hD1;
        m_rx_hdr_ready = 4'hF; m_rx_tready = 4'hF;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if ({m_tx_tvalid, m_rx_tvalid} !== 5'b1_0001) begin
            errors++; $display("FAIL mid_pay_active: got %b required 10001", {m_tx_tvalid, m_rx_tvalid});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({m_tx_hdr_valid, m_tx_tvalid, m_rx_hdr_valid, m_rx_tvalid, s_tx_tready, s_rx_tready,
             s_tx_hdr_ready, s_rx_hdr_ready} !== 20'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h required 0", {m_tx_hdr_valid, m_tx_tvalid,
                     m_rx_hdr_valid, m_rx_tvalid, s_tx_tready, s_rx_tready, s_tx_hdr_ready, s_rx_hdr_ready});
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 10 && !got; cyc++) begin
            @(negedge clk);
            s_tx_hdr_valid = 4'b1010;
            s_tx_hdr_data[80 +: 80]  = {32'd1, 16'd10, 16'd4003, 16'd1};
            s_tx_hdr_data[240 +: 80] = {32'd3, 16'd11, 16'd4003, 16'd1};
            m_tx_hdr_ready = 1'b1;
            #1;
            if (m_tx_hdr_valid) begin
                got = 1'b1;
                checks++;
                if ({m_tx_hdr_data, s_tx_hdr_ready} !== {32'd1, 16'd10, 16'd4003, 16'd1, 4'b0010}) begin
                    errors++; $display("FAIL post_reset_tx_grant: got %h ready %b required ch1 header ready 0010",
                                       m_tx_hdr_data, s_tx_hdr_ready);
                end
            end
        end
        checks++;
        if (got !== 1'b1) begin
            errors++; $display("FAIL post_reset_tx_timeout: got no header required one within 10 cycles");
        end
        @(negedge clk);
        idle_inputs();
        rx_packet(16'd1235, 3, 1, 8'hF0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_lock();
        test_rx_route();
        test_drop();
        test_reconfig();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
